// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU instruction fetch and
// data load/store. One requester is granted at a time. The captured access is
// held on the memory port until mem_ready arrives or the access times out.
// Completion is reported with a one-cycle ack.
//
// Ports:
//   clk, reset                      rising-edge clock, async active-high reset
//   if_req/if_addr -> if_ack/if_rdata   fetch request and completion
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_ack/d_rdata   load/store request and completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_rdata/mem_ready   memory side
//   busy         high whenever the arbiter is not idle
//   timeout_err  sticky abort flag, cleared only by reset
module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned SW = 4;
    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic            TO_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [SW-1:0]   STREAK_LIM = SW'(STREAK_MAX);
    localparam logic [TW-1:0]   TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            own_data_q, own_data_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic            if_ack_q, if_ack_d;
    logic            d_ack_q, d_ack_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            busy_q, busy_d;
    logic            terr_q, terr_d;

    logic            req_any;
    logic            grant_data;
    logic            tmo_hit;
    logic            access_end;
    logic [31:0]     cap_data;

    // Data wins contention until it has starved a waiting fetch STREAK_MAX times.
    assign req_any    = if_req | d_req;
    assign grant_data = d_req & ~(if_req & (streak_q == STREAK_LIM));

    // mem_ready beats a timeout landing in the same cycle.
    assign tmo_hit    = TO_EN & ~mem_ready & (tmo_q == TO_LAST);
    assign access_end = (state_q == S_ACCESS) & (mem_ready | tmo_hit);
    assign cap_data   = mem_ready ? mem_rdata : 32'h0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_any) state_d = S_ACCESS;
            S_ACCESS: if (access_end) state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the datapath and the registered outputs.
    always_comb begin
        own_data_d  = own_data_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        terr_d      = terr_q;
        busy_d      = (state_d != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    own_data_d = grant_data;
                    mem_req_d  = 1'b1;
                    tmo_d      = '0;
                    if (grant_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_we ? d_wstrb : 4'b0000;
                        // Streak only counts data grants that made a fetch wait.
                        if (!if_req)                   streak_d = '0;
                        else if (streak_q != STREAK_LIM) streak_d = streak_q + SW'(1);
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = 32'h0;
                        mem_wstrb_d = 4'b0000;
                        streak_d    = '0;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready || tmo_hit) begin
                    mem_req_d = 1'b0;
                    if (own_data_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) d_rdata_d = cap_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = cap_data;
                    end
                    if (!mem_ready) terr_d = 1'b1;
                end else if (TO_EN) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_data_q  <= 1'b0;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            own_data_q  <= own_data_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
            terr_q      <= terr_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a wait-state memory responder plus a
// transaction-level reference (word memory, streak rule, expected latency).
module tb_mem_port_arbiter;

    localparam int unsigned SM = 4;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STREAK_MAX(SM), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .timeout_err(timeout_err)
    );

    // ---------------- memory environment ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    logic [31:0] env_mem [bit [31:0]];
    logic [31:0] ref_mem [bit [31:0]];
    acc_t        mem_log [$];
    int          mem_wait = 0;     // wait states before ready; -1 = never ready
    bit          mem_en = 1'b1;
    int          resp_cnt = 0;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    logic        man_ready = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    acc_t        ent;
    logic [31:0] cur;

    assign mem_ready = mem_en ? resp_ready : man_ready;
    assign mem_rdata = mem_en ? resp_rdata : man_rdata;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    always @(negedge clk) begin
        if (reset || !mem_req) begin
            resp_cnt   = 0;
            resp_ready = 1'b0;
        end else begin
            if (resp_cnt == 0) begin
                ent.addr = mem_addr; ent.we = mem_we; ent.wdata = mem_wdata; ent.wstrb = mem_wstrb;
                mem_log.push_back(ent);
            end
            if (mem_wait >= 0 && resp_cnt == mem_wait) begin
                cur = env_mem.exists(mem_addr) ? env_mem[mem_addr] : mem_default(mem_addr);
                resp_rdata = cur;
                if (mem_we) env_mem[mem_addr] = merge(cur, mem_wdata, mem_wstrb);
                resp_ready = 1'b1;
            end else begin
                resp_ready = 1'b0;
                resp_rdata = $urandom;
            end
            resp_cnt++;
        end
    end

    // ---------------- reference state ----------------
    logic [31:0] exp_if_rdata = 32'h0;
    logic [31:0] exp_d_rdata  = 32'h0;
    logic        exp_terr     = 1'b0;
    int          streak_m     = 0;

    // Waits for the next ack, up to budget cycles; cyc=0 when none arrived.
    task automatic run_until_ack(input int budget, output int cyc, output logic ia, output logic da);
        cyc = 0; ia = 1'b0; da = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (if_ack === 1'b1 || d_ack === 1'b1) begin
                cyc = i; ia = if_ack; da = d_ack;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack,
             if_rdata, d_rdata, busy, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h ack=%b/%b busy=%b terr=%b, required all zero",
                     mem_req, mem_we, mem_addr, if_ack, d_ack, busy, timeout_err);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b mem_req=%b, required 0/0", busy, mem_req);
        end
    endtask

    task automatic test_single_fetch;
        mem_en = 1'b1; mem_wait = 0;
        env_mem[32'h4] = 32'h00200293; ref_mem[32'h4] = 32'h00200293;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h4;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h4 || mem_wstrb !== 4'h0 || mem_we !== 1'b0 || busy !== 1'b1 || if_ack !== 1'b0) begin
            failures++;
            $display("FAIL fetch_port: got req=%b addr=%h strb=%b we=%b busy=%b ack=%b, required 1/00000004/0000/0/1/0",
                     mem_req, mem_addr, mem_wstrb, mem_we, busy, if_ack);
        end
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h00200293) begin
            failures++;
            $display("FAIL fetch_ack: got if_ack=%b d_ack=%b rdata=%h, required 1/0/00200293", if_ack, d_ack, if_rdata);
        end
        if_req = 1'b0;
        exp_if_rdata = 32'h00200293;
        streak_m = 0;
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL fetch_ack_width: got if_ack=%b mem_req=%b, required 0/0", if_ack, mem_req);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_store;
        int req_cycles, bad, acks;
        req_cycles = 0; bad = 0; acks = 0;
        mem_wait = 3;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) bad++;
            end
            if (d_ack === 1'b1) begin acks++; d_req = 1'b0; end
            if (if_ack === 1'b1) bad++;
        end
        ref_mem[32'h100] = merge(ref_read(32'h100), 32'hDEADBEEF, 4'b0011);
        streak_m = 0;
        checks++;
        if (req_cycles != 4) begin
            failures++;
            $display("FAIL store_req_cycles: got %0d, required 4", req_cycles);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL store_port_stable: got %0d bad cycles, required 0", bad);
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL store_ack_count: got %0d, required 1", acks);
        end
        checks++;
        if (d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL store_rdata_held: got %h, required %h", d_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_random;
        int kind, w, cyc;
        logic ia, da;
        logic [31:0] a, wd, exp;
        logic [3:0] s;
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 2);
            a    = 32'h40 + 32'($urandom_range(0, 7)) * 4;
            wd   = $urandom;
            s    = 4'($urandom_range(1, 15));
            w    = $urandom_range(0, 3);
            @(negedge clk);
            mem_wait = w;
            mem_log.delete();
            if (kind == 0) begin
                if_req = 1'b1; if_addr = a;
            end else begin
                d_req = 1'b1; d_we = (kind == 2); d_addr = a; d_wdata = wd; d_wstrb = s;
            end
            run_until_ack(20, cyc, ia, da);
            if_req = 1'b0; d_req = 1'b0;
            streak_m = 0;
            exp = ref_read(a);
            if (kind == 0) exp_if_rdata = exp;
            else if (kind == 1) exp_d_rdata = exp;
            else ref_mem[a] = merge(exp, wd, s);
            checks++;
            if (cyc != w + 2 || ia !== (kind == 0) || da !== (kind != 0)) begin
                failures++;
                $display("FAIL rand_latency[%0d]: got cyc=%0d if_ack=%b d_ack=%b, required cyc=%0d kind=%0d",
                         k, cyc, ia, da, w + 2, kind);
            end
            checks++;
            if (mem_log.size() != 1) begin
                failures++;
                $display("FAIL rand_mem_count[%0d]: got %0d accesses, required 1", k, mem_log.size());
            end else if (mem_log[0].addr !== a || mem_log[0].we !== (kind == 2) ||
                         mem_log[0].wstrb !== ((kind == 2) ? s : 4'h0) ||
                         (kind == 2 && mem_log[0].wdata !== wd)) begin
                failures++;
                $display("FAIL rand_mem_fields[%0d]: got addr=%h we=%b strb=%b wdata=%h, required addr=%h kind=%0d strb=%b wdata=%h",
                         k, mem_log[0].addr, mem_log[0].we, mem_log[0].wstrb, mem_log[0].wdata, a, kind, s, wd);
            end
            checks++;
            if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
                failures++;
                $display("FAIL rand_rdata[%0d]: got if=%h d=%h, required if=%h d=%h",
                         k, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
            end
        end
    endtask

    task automatic test_contention;
        int cyc;
        logic ia, da, exp_i;
        mem_wait = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h48;
        for (int g = 0; g < 15; g++) begin
            run_until_ack(10, cyc, ia, da);
            if (g == 14) begin if_req = 1'b0; d_req = 1'b0; end
            if (streak_m == int'(SM)) begin
                exp_i = 1'b1; streak_m = 0;
                exp_if_rdata = ref_read(32'h8);
            end else begin
                exp_i = 1'b0; streak_m = streak_m + 1;
                exp_d_rdata = ref_read(32'h48);
            end
            checks++;
            if (ia !== exp_i || da !== ~exp_i || cyc != ((g == 0) ? 2 : 3)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got if_ack=%b d_ack=%b gap=%0d, required fetch=%b gap=%0d",
                         g, ia, da, cyc, exp_i, (g == 0) ? 2 : 3);
            end
            checks++;
            if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
                failures++;
                $display("FAIL contention_rdata[%0d]: got if=%h d=%h, required if=%h d=%h",
                         g, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL contention_drain: got busy=%b mem_req=%b, required 0/0", busy, mem_req);
        end
    endtask

    task automatic test_timeout_edge;
        int cyc;
        logic ia, da;
        @(negedge clk);
        mem_wait = int'(TO) - 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        run_until_ack(30, cyc, ia, da);
        d_req = 1'b0;
        streak_m = 0;
        exp_d_rdata = ref_read(32'h60);
        checks++;
        if (cyc != int'(TO) + 1 || da !== 1'b1 || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL ready_at_limit: got cyc=%0d d_ack=%b rdata=%h, required cyc=%0d 1 %h",
                     cyc, da, d_rdata, TO + 1, exp_d_rdata);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_limit_err: got timeout_err=%b, required 0", timeout_err);
        end
    endtask

    task automatic test_idle_ready;
        int stray;
        stray = 0;
        @(negedge clk);
        mem_en = 1'b0; man_ready = 1'b1; man_rdata = 32'hFFFF0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) stray++;
        end
        man_ready = 1'b0; mem_en = 1'b1;
        checks++;
        if (stray != 0 || if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
            failures++;
            $display("FAIL idle_ready_ignored: got %0d active cycles, if=%h d=%h, required 0 %h %h",
                     stray, if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
        end
    endtask

    task automatic test_timeout;
        int req_cycles, cyc;
        logic ia, da;
        req_cycles = 0; cyc = 0; da = 1'b0;
        @(negedge clk);
        mem_wait = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h70;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) req_cycles++;
            if (d_ack === 1'b1) begin cyc = i; da = 1'b1; break; end
        end
        d_req = 1'b0;
        exp_d_rdata = 32'h0; exp_terr = 1'b1; streak_m = 0;
        checks++;
        if (req_cycles != int'(TO) || cyc != int'(TO) + 1 || da !== 1'b1) begin
            failures++;
            $display("FAIL timeout_abort: got req_cycles=%0d ack_at=%0d d_ack=%b, required %0d %0d 1",
                     req_cycles, cyc, da, TO, TO + 1);
        end
        checks++;
        if (d_rdata !== 32'h0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_result: got d_rdata=%h terr=%b, required 00000000 1", d_rdata, timeout_err);
        end
        @(negedge clk);
        mem_wait = 0;
        if_req = 1'b1; if_addr = 32'hC;
        run_until_ack(10, cyc, ia, da);
        if_req = 1'b0;
        exp_if_rdata = ref_read(32'hC);
        checks++;
        if (cyc != 2 || ia !== 1'b1 || if_rdata !== exp_if_rdata || timeout_err !== exp_terr) begin
            failures++;
            $display("FAIL after_timeout_fetch: got cyc=%0d ack=%b rdata=%h terr=%b, required 2 1 %h %b",
                     cyc, ia, if_rdata, timeout_err, exp_if_rdata, exp_terr);
        end
    endtask

    task automatic test_reset_mid_access;
        int cyc;
        logic ia, da;
        @(negedge clk);
        mem_wait = -1;
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_access_active: got mem_req=%b busy=%b, required 1/1", mem_req, busy);
        end
        #2 reset = 1'b1;
        #1;
        exp_if_rdata = 32'h0; exp_d_rdata = 32'h0; exp_terr = 1'b0; streak_m = 0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0 ||
            timeout_err !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: got req=%b busy=%b acks=%b%b terr=%b addr=%h, required all zero",
                     mem_req, busy, if_ack, d_ack, timeout_err, mem_addr);
        end
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dropped_access: got if_ack=%b busy=%b, required 0/0", if_ack, busy);
        end
        if_req = 1'b1; if_addr = 32'h10;
        run_until_ack(10, cyc, ia, da);
        if_req = 1'b0;
        exp_if_rdata = ref_read(32'h10);
        checks++;
        if (cyc != 2 || ia !== 1'b1 || if_rdata !== exp_if_rdata || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_fetch: got cyc=%0d ack=%b rdata=%h terr=%b, required 2 1 %h 0",
                     cyc, ia, if_rdata, timeout_err, exp_if_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_random();
        test_contention();
        test_timeout_edge();
        test_idle_ready();
        test_timeout();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared memory port (MMU side) between CPU instruction fetch and data load/store.
- Grants one requester at a time and holds the captured access on the memory port until the memory responds.
- Returns read data with a one-cycle ack pulse.
- Sits between the cpu fetch/LSU logic and mmu in the soc; enables a single-port memory for the multi-cycle CPU.

Parameters:
- STREAK_MAX, 4: consecutive data grants allowed while a fetch is pending before fetch is forced (1..15).
- TIMEOUT_CYCLES, 64: ACCESS cycles without mem_ready before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held stable until if_ack
- if_addr  in  32  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched word; valid when if_ack=1, held until next fetch completion
- d_req  in  1  data request; held stable until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data; updated on load completion only, otherwise held
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables; forced to 4'b0000 on fetches and loads
- mem_rdata  in  32  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completion; sampled only in ACCESS
- busy  out  1  1 whenever state != IDLE
- timeout_err  out  1  sticky; set on timeout abort, cleared only by reset

Behaviour:
- Reset (async, any time, including mid-ACCESS):
  - state=IDLE; streak and timeout counters=0.
  - All outputs=0: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack, if_rdata, d_rdata, busy, timeout_err.
  - An in-flight access is dropped with no ack.
- FSM states IDLE, ACCESS, ACK. All outputs are registered.
- IDLE:
  - Samples requests. If any request is present, latch owner, address, we, wdata and wstrb; go to ACCESS.
  - mem_req rises the cycle after the request is sampled.
- Arbitration (IDLE only):
  - Only d_req: grant data.
  - Only if_req: grant fetch.
  - Both: grant data unless streak==STREAK_MAX, in which case grant fetch.
- Streak counter:
  - Increments on a data grant when if_req=1.
  - Clears on any fetch grant, or on a data grant with if_req=0.
  - Saturates at STREAK_MAX.
- ACCESS:
  - mem_req=1; address, we, wdata and wstrb stay constant.
  - On mem_ready=1: capture mem_rdata into the owner's rdata (d_rdata only if load), drop mem_req, go to ACK.
  - Timeout counter increments each ACCESS cycle without mem_ready. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0):
    - set timeout_err;
    - drop mem_req;
    - owner rdata=32'h0 (d_rdata only if load);
    - go to ACK.
  - mem_ready and timeout in the same cycle: mem_ready wins; no error.
- ACK:
  - Owner's ack=1 for exactly one cycle; requests are ignored; next state IDLE.
  - Requester must drop req the cycle after it sees ack.
- Latency: request sampled in IDLE at cycle N → mem_req high N+1 → if mem_ready at N+1, ack at N+2. Minimum 3 cycles per access; back-to-back grants are 3 cycles apart.
- mem_ready outside ACCESS is ignored.
- Request changes while not in IDLE are ignored; latched values are used.
- if_ack and d_ack are never high simultaneously.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000004, memory returns 0x00200293 with mem_ready 1 cycle after mem_req → mem_addr=0x4, mem_wstrb=0; if_ack pulses 1 cycle at N+2; if_rdata=0x00200293.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, 3 wait states → mem_we=1, mem_wstrb=4'b0011 stable for 4 cycles; d_ack once; d_rdata unchanged.
- Contention: if_req and d_req held continuously with STREAK_MAX=4, zero-wait memory → grant order D,D,D,D,I,D,…; if_ack and d_ack never coincide.
- Timeout: TIMEOUT_CYCLES=8, d load, mem_ready never asserted → mem_req drops after 8 ACCESS cycles; d_ack pulses; d_rdata=0; timeout_err=1 and stays 1; a following fetch completes normally.
- Reset mid-access: assert reset during ACCESS → mem_req, busy and acks go 0 immediately (asynchronously); state IDLE; after release, a new if_req completes with 3-cycle latency.
- Edge cases:
  - mem_ready pulse while IDLE → ignored, no ack.
  - mem_ready on the same cycle the timeout count is reached → normal completion, timeout_err stays 0.
